seg_scan_mux: RTL and testbench

Time-multiplexed scanner for a 4-digit common-anode seven-segment display. Holds a double-buffered 4-digit BCD value with per-digit decimal points and rotates through the digits at a fixed refresh rate. For each digit slot it drives the active-low anode enable and the active-low segment pattern. It sits between the datapath that produces numeric results and the board's display pins, and owns all display timing.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seven_seg.sv | 28 ++
 rtl/seg_scan_mux.sv | 158 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scanner.
//   digit_t          4-bit digit code (0-9 decoded, A-F blank)
//   SEG_0..SEG_9     active-low segment patterns, bit 7 = dp, bits 6:0 = g..a
//   SEG_BLANK        all segments off
//   AN_OFF           all anodes off (active-low)
package seg_pkg;

   typedef logic [3:0] digit_t;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/seven_seg.sv
// seven_seg: combinational digit-code to segment decoder (active-low).
//   code  in   digit code; 0-9 decode to numerals, A-F blank
//   seg   out  segments g..a, active-low (decimal point handled by the caller)
module seven_seg
   import seg_pkg::*;
(
   input  digit_t      code,
   output logic [6:0]  seg
);

   always_comb begin
      seg = SEG_BLANK[6:0];
      case (code)
         4'd0:    seg = SEG_0[6:0];
         4'd1:    seg = SEG_1[6:0];
         4'd2:    seg = SEG_2[6:0];
         4'd3:    seg = SEG_3[6:0];
         4'd4:    seg = SEG_4[6:0];
         4'd5:    seg = SEG_5[6:0];
         4'd6:    seg = SEG_6[6:0];
         4'd7:    seg = SEG_7[6:0];
         4'd8:    seg = SEG_8[6:0];
         4'd9:    seg = SEG_9[6:0];
         default: seg = SEG_BLANK[6:0];
      endcase
   end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 4-digit common-anode seven-segment scanner with a
// double-buffered display value that only changes at frame boundaries.
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   en           display enable (0 blanks outputs, scan keeps running)
//   digits       four BCD digits, digit 0 in bits 3:0 (rightmost)
//   dp           decimal point per digit, 1 = lit
//   load         strobe capturing digits/dp into the pending buffer
//   blink        (SEG_SCAN_BLINK_EN only) per-digit blink select
//   an           anode enables, active-low
//   seg          segments, active-low, bit 7 = dp, bits 6:0 = g..a
//   frame_start  one-cycle pulse on the first output cycle of digit 0
// Optional feature: define SEG_SCAN_BLINK_EN to add the blink input and
// the BLINK_FRAMES parameter.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 16
`ifdef SEG_SCAN_BLINK_EN
  ,parameter int unsigned BLINK_FRAMES = 250
`endif
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] digits,
   input  logic [3:0]  dp,
   input  logic        load,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [3:0]  blink,
`endif
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame_start
);

   localparam int unsigned      CNT_W     = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic             slot_end;
   logic             boundary;
   logic             wrap_q;

   logic [15:0]      pend_digits;
   logic [3:0]       pend_dp;
   logic             pend_valid;
   logic [15:0]      act_digits;
   logic [3:0]       act_dp;

   digit_t           cur_code;
   logic [6:0]       cur_seg;
   logic [3:0]       an_nxt;
   logic [7:0]       seg_nxt;

   assign slot_end = (cnt == CNT_MAX);
   assign boundary = slot_end && (idx == 2'd3);

   // Slot timer and digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Double buffer. A load on the boundary cycle bypasses pending and
   // wins over any stale pending value.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_digits <= '0;
         pend_dp     <= '0;
         pend_valid  <= 1'b0;
         act_digits  <= '1;
         act_dp      <= '0;
      end else if (boundary) begin
         if (load) begin
            act_digits <= digits;
            act_dp     <= dp;
         end else if (pend_valid) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
         end
         pend_valid <= 1'b0;
      end else if (load) begin
         pend_digits <= digits;
         pend_dp     <= dp;
         pend_valid  <= 1'b1;
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BF_W-1:0] blink_cnt;
   logic            blink_phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (boundary) begin
         if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
`endif

   assign cur_code = act_digits[{idx, 2'b00} +: 4];

   seven_seg u_dec (
      .code (cur_code),
      .seg  (cur_seg)
   );

   always_comb begin
      seg_nxt = {~act_dp[idx], cur_seg};
      an_nxt  = (cnt < CNT_BLANK) ? AN_OFF : ~(4'b0001 << idx);
`ifdef SEG_SCAN_BLINK_EN
      if (blink_phase) begin
         an_nxt = an_nxt | blink;
      end
`endif
      if (!en) begin
         an_nxt  = AN_OFF;
         seg_nxt = SEG_BLANK;
      end
   end

   // Registered outputs. wrap_q marks the cycle whose state is cnt=0/idx=0
   // after a wrap, so frame_start lines up with digit 0's first output.
   always_ff @(posedge clk) begin
      if (rst) begin
         an          <= AN_OFF;
         seg         <= SEG_BLANK;
         wrap_q      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         an          <= an_nxt;
         seg         <= seg_nxt;
         wrap_q      <= boundary;
         frame_start <= wrap_q;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  seg_scan_mux #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits      (digits),
    .dp          (dp),
    .load        (load),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input int c, input logic [3:0] a, input logic [7:0] s, input logic f);
    exp_t e;
    e.cyc = c;
    e.an  = a;
    e.seg = s;
    e.fs  = f;
    q.push_back(e);
  endtask

  task automatic push_frame(input int start,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input logic fs0, input int first, input int last,
                            input int off_lo, input int off_hi);
    int         t;
    logic [7:0] sv;
    logic [3:0] av;
    for (int c = 0; c < 32; c++) begin
      t = start + c;
      if (t >= first && t <= last) begin
        case (c / 8)
          0:       begin sv = s0; av = 4'b1110; end
          1:       begin sv = s1; av = 4'b1101; end
          2:       begin sv = s2; av = 4'b1011; end
          default: begin sv = s3; av = 4'b0111; end
        endcase
        if ((c % 8) < 2) av = 4'b1111;
        if (t >= off_lo && t <= off_hi) begin
          av = 4'b1111;
          sv = 8'hFF;
        end
        push(t, av, sv, (c == 0) ? fs0 : 1'b0);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    #1;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      mon_e = q.pop_front();
      n_checks++;
      $display("FAIL missed_check cyc=%0d (expected an=%b seg=%h)", mon_e.cyc, mon_e.an, mon_e.seg);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      n_checks++;
      if (an === mon_e.an && seg === mon_e.seg && frame_start === mon_e.fs)
        n_pass++;
      else
        $display("FAIL scan cyc=%0d got an=%b seg=%h fs=%b, expected an=%b seg=%h fs=%b",
                 cyc, an, seg, frame_start, mon_e.an, mon_e.seg, mon_e.fs);
    end
  end

  initial begin
    for (int c = 1; c <= 5; c++) push(c, 4'b1111, 8'hFF, 1'b0);
    push_frame(6, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 6, 37, -1, -1);
    push_frame(38, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, 38, 69, -1, -1);

    wait_cyc(3);
    #2;
    n_checks++;
    if (an === 4'b1111) n_pass++;
    else $display("FAIL reset_an cyc=%0d an=%b", cyc, an);
    n_checks++;
    if (seg === 8'hFF) n_pass++;
    else $display("FAIL reset_seg cyc=%0d seg=%h", cyc, seg);

    wait_cyc(5);
    rst = 1'b0;

    wait_cyc(9);
    digits = 16'h1234; dp = 4'b0000; load = 1'b1;
    wait_cyc(10);
    load = 1'b0;

    wait_cyc(38);
    #2;
    n_checks++;
    if (frame_start === 1'b1) n_pass++;
    else $display("FAIL frame_start cyc=%0d fs=%b", cyc, frame_start);

    wait_cyc(47);
    push_frame(70, 8'h80, 8'hF8, 8'h82, 8'h92, 1'b1, 70, 101, -1, -1);
    digits = 16'h5678; load = 1'b1;
    wait_cyc(48);
    load = 1'b0;

    wait_cyc(79);
    push_frame(102, 8'h7F, 8'hFF, 8'hC0, 8'hC0, 1'b1, 102, 133, -1, -1);
    push_frame(134, 8'h7F, 8'hFF, 8'hC0, 8'hC0, 1'b1, 134, 165, 152, 154);
    push_frame(166, 8'h7F, 8'hFF, 8'hC0, 8'hC0, 1'b1, 166, 174, -1, -1);
    digits = 16'h9999; dp = 4'b1111; load = 1'b1;
    wait_cyc(80);
    load = 1'b0;
    wait_cyc(100);
    digits = 16'h00AF; dp = 4'b0001; load = 1'b1;
    wait_cyc(101);
    load = 1'b0;

    wait_cyc(151);
    en = 1'b0;
    wait_cyc(153);
    #2;
    n_checks++;
    if (an === 4'b1111) n_pass++;
    else $display("FAIL en_off_an cyc=%0d an=%b", cyc, an);
    n_checks++;
    if (seg === 8'hFF) n_pass++;
    else $display("FAIL en_off_seg cyc=%0d seg=%h", cyc, seg);
    wait_cyc(154);
    en = 1'b1;

    wait_cyc(169);
    push(175, 4'b1111, 8'hFF, 1'b0);
    push_frame(176, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 176, 207, -1, -1);
    push_frame(208, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 208, 239, -1, -1);
    digits = 16'h4321; dp = 4'b1111; load = 1'b1;
    wait_cyc(170);
    load = 1'b0;
    wait_cyc(174);
    rst = 1'b1;
    wait_cyc(175);
    rst = 1'b0;

    wait_cyc(245);
    #2;
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_checks++;
      $display("FAIL unchecked cyc=%0d (expected an=%b seg=%h)", mon_e.cyc, mon_e.an, mon_e.seg);
    end
    if (n_checks < 12)
      $display("FAIL too_few_checks n_checks=%0d", n_checks);
    if (n_pass != n_checks)
      $display("FAIL summary %0d of %0d checks failed", n_checks - n_pass, n_checks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
